switch_scan_debouncer: RTL and testbench
========================================

Name: switch_scan_debouncer

Overview:
- Debounces NUM_SW board switches using one shared sample-tick prescaler and one shared compare/update datapath.
- A scan sequencer services one channel per clock after each sample tick.
- Outputs are per-switch debounced levels plus one-cycle press/release event pulses.
- Sits between the raw board switch pins and the game/VGA control logic; replaces per-switch free-running debounce counters.

Parameters:
- NUM_SW, 4: number of switch channels, 1..8.
- TICK_DIV, 250: clock cycles per sample tick; must be greater than NUM_SW+1 (10 us at 25 MHz).
- STABLE_TICKS, 1000: consecutive differing samples required to accept a new level (10 ms); minimum 2.

Ports:
- i_Clk  input  1  system clock.
- i_Rst_L  input  1  asynchronous active-low reset.
- i_Switch  input  NUM_SW  raw, unsynchronised switch inputs.
- o_Switch  output  NUM_SW  debounced switch levels.
- o_Press  output  NUM_SW  one-cycle pulse on a debounced 0->1 transition.
- o_Release  output  NUM_SW  one-cycle pulse on a debounced 1->0 transition.
- o_Busy  output  1  high while the scan sequencer is in SCAN.

Behaviour:
- Reset (i_Rst_L=0, asynchronous, any cycle): all registers clear immediately.
  - Synchroniser flops, prescaler, snapshot, per-channel counters, scan index, FSM (=IDLE): 0.
  - o_Switch, o_Press, o_Release, o_Busy: 0.
  - Reset mid-count or mid-scan discards all partial progress; no pulse is emitted.
- Synchroniser: two flops per bit; sync[k] is i_Switch[k] delayed 2 cycles.
- Prescaler: counts 0..TICK_DIV-1 and wraps. Tick is asserted in the cycle the count equals TICK_DIV-1. It free-runs and is never stalled by the scan.
- FSM IDLE:
  - On tick, snapshot <= sync (all channels sampled in the same cycle), idx <= 0, go to SCAN.
- FSM SCAN:
  - Each cycle, service channel idx, then idx <= idx+1.
  - After idx = NUM_SW-1, return to IDLE.
  - A scan always takes exactly NUM_SW cycles; o_Busy = (state==SCAN).
  - Because TICK_DIV > NUM_SW+1, a tick never occurs in SCAN. This is a parameter constraint, checked by an elaboration-time assertion.
- Channel update, for channel k serviced this cycle:
  - If snapshot[k] == o_Switch[k]: cnt[k] <= 0.
  - Else if cnt[k] == STABLE_TICKS-1: o_Switch[k] <= snapshot[k], cnt[k] <= 0, and the matching o_Press[k] or o_Release[k] is asserted in the next cycle (same edge as the o_Switch change becomes visible), for exactly one cycle.
  - Else: cnt[k] <= cnt[k]+1.
- Counter width is clog2(STABLE_TICKS). Counters never exceed STABLE_TICKS-1, so they have no wrap case.
- Channels other than idx hold their state. Several channels may each pulse in the same scan, on consecutive cycles, never simultaneously.
- Any single sample equal to the current level resets that channel's count; bounces restart the window.
- Latency: the new level is accepted at the STABLE_TICKS-th consecutive differing tick, plus k+1 cycles for channel k.
- After reset with a switch held high, o_Switch rises after STABLE_TICKS ticks and o_Press fires once.
- o_Press and o_Release are never high together for the same channel.

Test Plan (NUM_SW=4, TICK_DIV=8, STABLE_TICKS=4):
- Reset with i_Switch=4'b0000, run 100 cycles -> all outputs 0, o_Busy high exactly 4 cycles in every 8.
- Raise i_Switch[2] cleanly -> o_Switch[2] rises on the 4th tick sampling 1, 3 cycles after that tick. o_Press[2] is high exactly 1 cycle, coincident with it. No other channel changes.
- Toggle i_Switch[1] high for 20 cycles (at most 3 ticks) then low -> o_Switch[1] stays 0, no pulses. Hold high 40 cycles -> accepted once.
- Raise all 4 switches in the same cycle -> o_Press[0..3] pulse on 4 consecutive cycles, in order 0,1,2,3. Lowering all gives o_Release in the same order.
- Hold i_Switch[3]=1 for 3 ticks, assert i_Rst_L=0 mid-scan for 2 cycles, release -> outputs 0 immediately. o_Switch[3] needs 4 fresh ticks; exactly one o_Press[3].
- Drop i_Switch[0] while o_Switch[0]=1 -> o_Release[0] one cycle, o_Press[0] stays 0 throughout.

Source files
------------

// File: rtl/switch_scan_debouncer_if.sv
// Switch debouncer signal bundle.
//   i_Switch  : raw, unsynchronised switch pins (driven by the board side)
//   o_Switch  : debounced levels
//   o_Press   : one-cycle pulse on a debounced 0->1 transition
//   o_Release : one-cycle pulse on a debounced 1->0 transition
//   o_Busy    : high while the scan sequencer walks the channels
// master drives the raw pins and observes the results; slave is the debouncer.
interface switch_scan_debouncer_if #(
  parameter int NUM_SW = 4
);
  logic [NUM_SW-1:0] i_Switch;
  logic [NUM_SW-1:0] o_Switch;
  logic [NUM_SW-1:0] o_Press;
  logic [NUM_SW-1:0] o_Release;
  logic              o_Busy;

  modport master (output i_Switch, input o_Switch, o_Press, o_Release, o_Busy);
  modport slave  (input i_Switch, output o_Switch, o_Press, o_Release, o_Busy);
endinterface

// File: rtl/switch_scan_debouncer.sv
// Time-multiplexed switch debouncer.
// One free-running prescaler produces a sample tick; on each tick every
// synchronised switch is snapshotted together, then a scan sequencer visits
// one channel per clock and runs that channel's compare/update step.
// Ports:
//   i_Clk   : system clock
//   i_Rst_L : asynchronous active-low reset
//   sw      : switch_scan_debouncer_if.slave (raw pins in, levels/pulses/busy out)

// Per-channel state: debounced level, run-length counter, event pulses.
// svc is high for the single cycle in which the scanner owns this channel.
module switch_scan_debouncer_lane #(
  parameter int STABLE_TICKS = 1000,
  parameter int CW           = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic svc,
  input  logic smp,
  output logic lvl,
  output logic press,
  output logic rel
);
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      lvl   <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      press <= 1'b0;
      rel   <= 1'b0;
      if (svc) begin
        if (smp == lvl) begin
          // any agreeing sample restarts the window
          cnt <= '0;
        end else if (cnt == CW'(STABLE_TICKS - 1)) begin
          lvl   <= smp;
          cnt   <= '0;
          press <= smp;
          rel   <= ~smp;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end
endmodule

module switch_scan_debouncer #(
  parameter int NUM_SW       = 4,
  parameter int TICK_DIV     = 250,
  parameter int STABLE_TICKS = 1000
) (
  input logic                  i_Clk,
  input logic                  i_Rst_L,
  switch_scan_debouncer_if.slave sw
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(STABLE_TICKS);
  localparam int IW = (NUM_SW > 1) ? $clog2(NUM_SW) : 1;

  // A scan must finish before the next tick can arrive.
  if (TICK_DIV <= NUM_SW + 1) begin : g_bad_div
    $error("TICK_DIV must exceed NUM_SW+1");
  end
  if (NUM_SW < 1 || NUM_SW > 8) begin : g_bad_nsw
    $error("NUM_SW must be 1..8");
  end
  if (STABLE_TICKS < 2) begin : g_bad_stable
    $error("STABLE_TICKS must be at least 2");
  end

  typedef enum logic {IDLE, SCAN} state_t;

  state_t            state;
  logic [PW-1:0]     pcnt;
  logic              tick;
  logic [NUM_SW-1:0] sync1, sync2;
  logic [NUM_SW-1:0] snap;
  logic [IW-1:0]     idx;
  logic              busy;
  logic [NUM_SW-1:0] svc, lvl, press, rel;

  assign tick = (pcnt == PW'(TICK_DIV - 1));

  // Prescaler free-runs; the scan never stalls it.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) pcnt <= '0;
    else          pcnt <= tick ? '0 : pcnt + PW'(1);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw.i_Switch;
      sync2 <= sync1;
    end
  end

  // Scan sequencer: snapshot all channels on tick, then walk idx 0..NUM_SW-1.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state <= IDLE;
      snap  <= '0;
      idx   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (tick) begin
          snap  <= sync2;
          idx   <= '0;
          state <= SCAN;
          busy  <= 1'b1;
        end
        SCAN: begin
          idx <= idx + IW'(1);
          if (idx == IW'(NUM_SW - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < NUM_SW; k++) begin : g_svc
    assign svc[k] = (state == SCAN) && (idx == IW'(k));
  end

  switch_scan_debouncer_lane #(
    .STABLE_TICKS(STABLE_TICKS),
    .CW(CW)
  ) u_lane [NUM_SW-1:0] (
    .clk  (i_Clk),
    .rst_n(i_Rst_L),
    .svc  (svc),
    .smp  (snap),
    .lvl  (lvl),
    .press(press),
    .rel  (rel)
  );

  assign sw.o_Switch  = lvl;
  assign sw.o_Press   = press;
  assign sw.o_Release = rel;
  assign sw.o_Busy    = busy;
endmodule

// File: tb/tb_switch_scan_debouncer.sv
// Directed bench for switch_scan_debouncer (NUM_SW=4, TICK_DIV=8, STABLE_TICKS=4).
// Scans are located by the rising edge of o_Busy; within a scan, sample n
// (negedge) sees channel k's update once n >= k+1.
module tb_switch_scan_debouncer;
  localparam int NSW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  switch_scan_debouncer_if #(.NUM_SW(NSW)) sw_if ();

  switch_scan_debouncer #(
    .NUM_SW(NSW),
    .TICK_DIV(8),
    .STABLE_TICKS(4)
  ) dut (
    .i_Clk  (clk),
    .i_Rst_L(rst_n),
    .sw     (sw_if)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Advance to sample 0 of the next scan; outputs must hold still meanwhile.
  task automatic next_scan(input string tag, input logic [3:0] sw_exp);
    logic prev;
    bit   hit;
    prev = sw_if.o_Busy;
    hit  = 1'b0;
    for (int n = 0; n < 20 && !hit; n++) begin
      step();
      if (sw_if.o_Busy && !prev) hit = 1'b1;
      else begin
        chk({tag, "_idle_sw"}, sw_if.o_Switch, sw_exp);
        chk({tag, "_idle_ev"}, {sw_if.o_Press, sw_if.o_Release}, 0);
      end
      prev = sw_if.o_Busy;
    end
    chk({tag, "_scan_found"}, hit, 1);
  endtask

  // Walk one scan from sample 0 to the first idle sample and check each cycle.
  task automatic run_scan(input string tag, input logic [3:0] bef, input logic [3:0] aft,
                          input logic [3:0] pm, input logic [3:0] rm);
    logic [3:0] esw, ep, er;
    next_scan(tag, bef);
    for (int off = 0; off < 5; off++) begin
      if (off > 0) step();
      for (int k = 0; k < 4; k++) begin
        esw[k] = (off >= k + 1) ? aft[k] : bef[k];
        ep[k]  = pm[k] && (off == k + 1);
        er[k]  = rm[k] && (off == k + 1);
      end
      chk({tag, "_sw"},    sw_if.o_Switch,  esw);
      chk({tag, "_press"}, sw_if.o_Press,   ep);
      chk({tag, "_rel"},   sw_if.o_Release, er);
      chk({tag, "_busy"},  sw_if.o_Busy,    off < 4);
    end
  endtask

  // Three quiet scans then the accepting one.
  task automatic accept4(input string tag, input logic [3:0] bef, input logic [3:0] aft,
                         input logic [3:0] pm, input logic [3:0] rm);
    for (int s = 0; s < 3; s++) run_scan(tag, bef, bef, 4'b0, 4'b0);
    run_scan(tag, bef, aft, pm, rm);
  endtask

  initial begin
    int nb;
    sw_if.i_Switch = 4'b0000;
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_sw",   sw_if.o_Switch,  0);
    chk("rst_ev",   {sw_if.o_Press, sw_if.o_Release}, 0);
    chk("rst_busy", sw_if.o_Busy,    0);
    rst_n = 1'b1;

    // Quiet inputs: outputs stay 0, busy is 4 of every 8 cycles.
    next_scan("t1", 4'b0);
    for (int w = 0; w < 12; w++) begin
      nb = 0;
      for (int c = 0; c < 8; c++) begin
        nb += int'(sw_if.o_Busy);
        chk("t1_out", {sw_if.o_Switch, sw_if.o_Press, sw_if.o_Release}, 0);
        step();
      end
      chk("t1_busy_duty", nb, 4);
    end
    run_scan("t1_align", 4'b0, 4'b0, 4'b0, 4'b0);

    // Clean rise on channel 2.
    sw_if.i_Switch = 4'b0100;
    accept4("t2", 4'b0000, 4'b0100, 4'b0100, 4'b0000);

    // Short pulse on channel 1 (3 ticks) is rejected.
    sw_if.i_Switch = 4'b0110;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("t3_short_sw", sw_if.o_Switch, 4'b0100);
      chk("t3_short_ev", {sw_if.o_Press, sw_if.o_Release}, 0);
    end
    sw_if.i_Switch = 4'b0100;
    for (int s = 0; s < 4; s++) run_scan("t3_rej", 4'b0100, 4'b0100, 4'b0, 4'b0);
    // Long hold is accepted once.
    sw_if.i_Switch = 4'b0110;
    accept4("t3_long", 4'b0100, 4'b0110, 4'b0010, 4'b0000);
    run_scan("t3_hold", 4'b0110, 4'b0110, 4'b0, 4'b0);
    sw_if.i_Switch = 4'b0000;
    accept4("t3_drop", 4'b0110, 4'b0000, 4'b0000, 4'b0110);

    // All channels together: pulses on consecutive cycles, 0..3.
    sw_if.i_Switch = 4'b1111;
    accept4("t4_up", 4'b0000, 4'b1111, 4'b1111, 4'b0000);
    sw_if.i_Switch = 4'b0000;
    accept4("t4_dn", 4'b1111, 4'b0000, 4'b0000, 4'b1111);

    // Reset mid-scan after 3 agreeing ticks discards the partial count.
    sw_if.i_Switch = 4'b1000;
    for (int s = 0; s < 3; s++) run_scan("t5_pre", 4'b0, 4'b0, 4'b0, 4'b0);
    next_scan("t5_pre", 4'b0);
    step();
    chk("t5_midscan_busy", sw_if.o_Busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", sw_if.o_Busy, 0);
    chk("t5_rst_out", {sw_if.o_Switch, sw_if.o_Press, sw_if.o_Release}, 0);
    step();
    step();
    chk("t5_rst_hold", {sw_if.o_Switch, sw_if.o_Press, sw_if.o_Release, 3'b000, sw_if.o_Busy}, 0);
    rst_n = 1'b1;
    accept4("t5_post", 4'b0000, 4'b1000, 4'b1000, 4'b0000);

    // Channel 0 up then down: release only, no press on the fall.
    sw_if.i_Switch = 4'b1001;
    accept4("t6_up", 4'b1000, 4'b1001, 4'b0001, 4'b0000);
    sw_if.i_Switch = 4'b1000;
    accept4("t6_dn", 4'b1001, 4'b1000, 4'b0000, 4'b0001);
    run_scan("t6_tail", 4'b1000, 4'b1000, 4'b0, 4'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want bench completion");
    $fatal(1, "watchdog");
  end
endmodule
